// File: rtl/simd_alu_pipe.sv
`default_nettype none
// ============================================================================
// Module      : simd_alu_pipe
// Description : Two-stage pipelined SIMD ALU with N independent unsigned
//               lanes of L bits. Supports NOP/ADD/SUB/MUL/SMUL/THR/CMP/MAC
//               with optional per-beat saturation and per-lane
//               accumulators for MAC. Valid/ready handshaking on both sides.
//
// Ports       : clk, rst (async, active-high)
//               in_valid / in_ready / op[2:0] / sat / a[W-1:0] / b[W-1:0]
//               acc_clr      - synchronous clear of all lane accumulators
//               out_valid / out_ready / c[W-1:0]
//
// Revision    : 1.0 - initial release
// ============================================================================
module simd_alu_pipe #(
    parameter int N = 4,
    parameter int L = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic             sat,
    input  logic [N*L-1:0]   a,
    input  logic [N*L-1:0]   b,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N*L-1:0]   c
);

    localparam int W = N * L;

    localparam logic [2:0] c_op_nop  = 3'd0;
    localparam logic [2:0] c_op_add  = 3'd1;
    localparam logic [2:0] c_op_sub  = 3'd2;
    localparam logic [2:0] c_op_mul  = 3'd3;
    localparam logic [2:0] c_op_smul = 3'd4;
    localparam logic [2:0] c_op_thr  = 3'd5;
    localparam logic [2:0] c_op_cmp  = 3'd6;
    localparam logic [2:0] c_op_mac  = 3'd7;

    localparam logic [L-1:0] c_lane_max  = {L{1'b1}};
    localparam logic [L-1:0] c_lane_zero = {L{1'b0}};
    localparam logic [L-1:0] c_lane_one  = {{(L-1){1'b0}}, 1'b1};

    // Stage 1: captured operand beat
    logic           r_s1_valid;
    logic [2:0]     r_s1_op;
    logic           r_s1_sat;
    logic [W-1:0]   r_s1_a;
    logic [W-1:0]   r_s1_b;

    // Stage 2: registered result
    logic           r_s2_valid;
    logic [W-1:0]   r_c;

    logic           w_advance;
    logic           w_mac_upd;
    logic [L-1:0]   w_s;
    logic [W-1:0]   w_res;

    // Both stages move together; the pipe only stalls when a result is
    // sitting at the output and downstream refuses it.
    assign w_advance = !r_s2_valid || out_ready;
    assign in_ready  = w_advance;
    assign out_valid = r_s2_valid;
    assign c         = r_c;

    assign w_s       = r_s1_b[L-1:0];
    assign w_mac_upd = w_advance && r_s1_valid && (r_s1_op == c_op_mac);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_op    <= c_op_nop;
            r_s1_sat   <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s2_valid <= 1'b0;
            r_c        <= '0;
        end else if (w_advance) begin
            r_s1_valid <= in_valid;
            r_s1_op    <= op;
            r_s1_sat   <= sat;
            r_s1_a     <= a;
            r_s1_b     <= b;
            r_s2_valid <= r_s1_valid;
            // Bubbles leave the previous result on c.
            if (r_s1_valid) begin
                r_c <= w_res;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_lane
            logic [L-1:0]   w_la;
            logic [L-1:0]   w_lb;
            logic [L-1:0]   w_mb;
            logic [L-1:0]   w_acc_src;
            logic [L-1:0]   w_lane_res;
            logic [L:0]     w_sum;
            logic [L:0]     w_dif;
            logic [2*L-1:0] w_prod;
            logic [2*L:0]   w_mac;
            logic [L-1:0]   r_acc;

            assign w_la = r_s1_a[gi*L +: L];
            assign w_lb = r_s1_b[gi*L +: L];
            // One shared multiplier per lane serves MUL, SMUL and MAC.
            assign w_mb = (r_s1_op == c_op_smul) ? w_s : w_lb;

            // A clear coinciding with a MAC makes that MAC start from zero.
            assign w_acc_src = acc_clr ? c_lane_zero : r_acc;

            assign w_sum  = {1'b0, w_la} + {1'b0, w_lb};
            // Bit L of the difference is the borrow out.
            assign w_dif  = {1'b0, w_la} - {1'b0, w_lb};
            assign w_prod = {{L{1'b0}}, w_la} * {{L{1'b0}}, w_mb};
            assign w_mac  = {1'b0, w_prod} + {{(L+1){1'b0}}, w_acc_src};

            always_comb begin
                w_lane_res = w_la;
                case (r_s1_op)
                    c_op_nop:  w_lane_res = w_la;
                    c_op_add:  w_lane_res = (r_s1_sat && w_sum[L]) ? c_lane_max : w_sum[L-1:0];
                    c_op_sub:  w_lane_res = (r_s1_sat && w_dif[L]) ? c_lane_zero : w_dif[L-1:0];
                    c_op_mul,
                    c_op_smul: w_lane_res = (r_s1_sat && (|w_prod[2*L-1:L])) ? c_lane_max : w_prod[L-1:0];
                    c_op_thr:  w_lane_res = (w_la > w_s) ? w_la : w_s;
                    c_op_cmp:  w_lane_res = (w_la > w_s) ? c_lane_one : c_lane_zero;
                    c_op_mac:  w_lane_res = (r_s1_sat && (|w_mac[2*L:L])) ? c_lane_max : w_mac[L-1:0];
                    default:   w_lane_res = w_la;
                endcase
            end

            assign w_res[gi*L +: L] = w_lane_res;

            // Updated as the MAC leaves S1, so a following MAC already in S1
            // sees the new value on the next cycle.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_acc <= '0;
                end else if (acc_clr) begin
                    r_acc <= '0;
                end else if (w_mac_upd) begin
                    r_acc <= w_lane_res;
                end
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_simd_alu_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_simd_alu_pipe
// Description : Directed scoreboard testbench for simd_alu_pipe (N=4, L=16).
//               Driver pushes hand-computed expected results on acceptance;
//               an independent monitor pops and compares on each transfer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_simd_alu_pipe;

    localparam int N = 4;
    localparam int L = 16;
    localparam int W = N * L;

    localparam logic [2:0] c_nop  = 3'd0;
    localparam logic [2:0] c_add  = 3'd1;
    localparam logic [2:0] c_sub  = 3'd2;
    localparam logic [2:0] c_mul  = 3'd3;
    localparam logic [2:0] c_smul = 3'd4;
    localparam logic [2:0] c_thr  = 3'd5;
    localparam logic [2:0] c_cmp  = 3'd6;
    localparam logic [2:0] c_mac  = 3'd7;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   op;
    logic         sat;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         acc_clr;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] c;

    simd_alu_pipe #(.N(N), .L(L)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .sat       (sat),
        .a         (a),
        .b         (b),
        .acc_clr   (acc_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c         (c)
    );

    typedef struct {
        logic [W-1:0] data;
        int           cyc;
        bit           lat;
    } sb_item_t;

    sb_item_t sb[$];
    int       n_chk   = 0;
    int       n_fail  = 0;
    int       cyc     = 0;
    bit       lat_chk = 1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    function automatic logic [W-1:0] v4(input logic [15:0] x0, x1, x2, x3);
        return {x3, x2, x1, x0};
    endfunction

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: one comparison per transferred result.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_output: got %h expected no output", c);
            end else begin
                sb_item_t it;
                it = sb.pop_front();
                chk("result", c, it.data);
                if (it.lat) begin
                    chk("latency", W'(cyc - it.cyc), W'(2));
                end
            end
        end
    end

    task automatic send(input logic [2:0] o, input logic s,
                        input logic [W-1:0] aa, input logic [W-1:0] bb,
                        input logic [W-1:0] exp);
        int  t;
        bit  done;
        sb_item_t it;
        t    = 0;
        done = 0;
        in_valid = 1'b1;
        op  = o;
        sat = s;
        a   = aa;
        b   = bb;
        while (!done && t < 100) begin
            @(negedge clk);
            if (in_ready) begin
                done    = 1;
                it.data = exp;
                it.cyc  = cyc;
                it.lat  = lat_chk;
                sb.push_back(it);
            end
            @(posedge clk);
            #1;
            t++;
        end
        in_valid = 1'b0;
        if (!done) begin
            n_chk++;
            n_fail++;
            $display("FAIL accept_timeout: got no in_ready expected acceptance");
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [W-1:0] hold;
        int           t;

        rst       = 1'b0;
        in_valid  = 1'b0;
        op        = c_nop;
        sat       = 1'b0;
        a         = '0;
        b         = '0;
        acc_clr   = 1'b0;
        out_ready = 1'b1;

        // Reset with a beat presented that must be discarded.
        #1;
        rst      = 1'b1;
        in_valid = 1'b1;
        op       = c_add;
        a        = v4(16'h1111, 16'h1111, 16'h1111, 16'h1111);
        b        = a;
        #1;
        chk("reset_out_valid", W'(out_valid), W'(0));
        chk("reset_c", c, '0);
        chk("reset_in_ready", W'(in_ready), W'(1));
        repeat (3) @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        idle(2);

        // Arithmetic / logic stream, back-to-back.
        send(c_add, 0, v4(16'hFFFF, 1, 2, 3), v4(2, 1, 1, 1), v4(16'h0001, 2, 3, 4));
        send(c_add, 1, v4(16'hFFFF, 1, 2, 3), v4(2, 1, 1, 1), v4(16'hFFFF, 2, 3, 4));
        send(c_sub, 1, v4(5, 0, 9, 1), v4(7, 1, 9, 0), v4(0, 0, 0, 1));
        send(c_sub, 0, v4(5, 0, 9, 1), v4(7, 1, 9, 0), v4(16'hFFFE, 16'hFFFF, 0, 1));
        send(c_cmp, 1, v4(6, 5, 4, 16'hFFFF), v4(5, 9, 9, 9), v4(1, 0, 0, 1));
        send(c_smul, 1, v4(16'h0100, 2, 0, 16'h00FF), v4(16'h0100, 7, 7, 7),
             v4(16'hFFFF, 16'h0200, 0, 16'hFF00));
        send(c_smul, 0, v4(16'h0100, 2, 0, 16'h00FF), v4(16'h0100, 7, 7, 7),
             v4(16'h0000, 16'h0200, 0, 16'hFF00));
        send(c_nop, 1, v4(16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0), v4(1, 1, 1, 1),
             v4(16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0));
        send(c_thr, 1, v4(3, 8, 9, 16'hFFFF), v4(8, 0, 16'hFFFF, 0), v4(8, 8, 9, 16'hFFFF));
        send(c_mul, 0, v4(16'h0100, 3, 16'hFFFF, 16'h10), v4(16'h0100, 5, 2, 16'h10),
             v4(16'h0000, 16'h000F, 16'hFFFE, 16'h0100));
        send(c_mul, 1, v4(16'h0100, 3, 16'hFFFF, 16'h10), v4(16'h0100, 5, 2, 16'h10),
             v4(16'hFFFF, 16'h000F, 16'hFFFF, 16'h0100));
        idle(3);

        // MAC accumulate back-to-back.
        send(c_mac, 0, v4(2, 2, 2, 2), v4(2, 2, 2, 2), v4(4, 4, 4, 4));
        send(c_mac, 0, v4(2, 2, 2, 2), v4(2, 2, 2, 2), v4(8, 8, 8, 8));
        send(c_mac, 0, v4(2, 2, 2, 2), v4(2, 2, 2, 2), v4(12, 12, 12, 12));
        idle(2);
        acc_clr = 1'b1;
        idle(1);
        acc_clr = 1'b0;
        send(c_mac, 0, v4(3, 3, 3, 3), v4(1, 1, 1, 1), v4(3, 3, 3, 3));
        // Saturating accumulate: acc {3,3,3,3} -> {FFFF,4,3,FFFF}
        send(c_mac, 1, v4(16'hFFFF, 1, 0, 16'h100), v4(2, 1, 5, 16'h100),
             v4(16'hFFFF, 4, 3, 16'hFFFF));
        // Wrapping accumulate on the saturated values
        send(c_mac, 0, v4(1, 1, 1, 1), v4(1, 1, 1, 1), v4(0, 5, 4, 0));
        // Clear coinciding with the MAC update: output uses 0 + a*b
        send(c_mac, 0, v4(2, 2, 2, 2), v4(2, 2, 2, 2), v4(4, 4, 4, 4));
        acc_clr = 1'b1;
        idle(1);
        acc_clr = 1'b0;
        send(c_mac, 0, v4(1, 1, 1, 1), v4(1, 1, 1, 1), v4(1, 1, 1, 1));
        idle(3);

        // Backpressure: 4 streamed beats, out_ready low for 3 cycles.
        lat_chk = 0;
        fork
            begin
                send(c_add, 0, v4(10, 10, 10, 10), v4(1, 1, 1, 1), v4(11, 11, 11, 11));
                send(c_add, 0, v4(20, 20, 20, 20), v4(2, 2, 2, 2), v4(22, 22, 22, 22));
                send(c_add, 0, v4(30, 30, 30, 30), v4(3, 3, 3, 3), v4(33, 33, 33, 33));
                send(c_add, 0, v4(40, 40, 40, 40), v4(4, 4, 4, 4), v4(44, 44, 44, 44));
            end
            begin
                t = 0;
                @(negedge clk);
                while (!out_valid && t < 20) begin
                    @(negedge clk);
                    t++;
                end
                @(posedge clk);
                #1;
                out_ready = 1'b0;
                @(negedge clk);
                hold = c;
                chk("bp_out_valid", W'(out_valid), W'(1));
                for (int i = 0; i < 3; i++) begin
                    if (i > 0) @(negedge clk);
                    chk("bp_in_ready", W'(in_ready), W'(0));
                    chk("bp_c_stable", c, hold);
                    @(posedge clk);
                end
                #1;
                out_ready = 1'b1;
            end
        join
        idle(4);
        lat_chk = 1;

        // Reset with two MAC beats in flight.
        send(c_mac, 0, v4(5, 5, 5, 5), v4(5, 5, 5, 5), v4(25, 25, 25, 25));
        send(c_mac, 0, v4(5, 5, 5, 5), v4(5, 5, 5, 5), v4(50, 50, 50, 50));
        #2;
        rst = 1'b1;
        sb.delete();
        #1;
        chk("midreset_out_valid", W'(out_valid), W'(0));
        chk("midreset_c", c, '0);
        chk("midreset_in_ready", W'(in_ready), W'(1));
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(1);
        send(c_mac, 0, v4(2, 2, 2, 2), v4(3, 3, 3, 3), v4(6, 6, 6, 6));

        // Drain the scoreboard.
        t = 0;
        while (sb.size() != 0 && t < 50) begin
            @(posedge clk);
            t++;
        end
        #1;
        chk("drain_empty", W'(sb.size()), W'(0));
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/simd_alu_pipe.md
SIMD_ALU_PIPE -- requirements
Module: simd_alu_pipe

Interface
REQ-001 Parameter N, default 4, lane count (N >= 1).
REQ-002 Parameter L, default 16, lane width in bits (L >= 2).
REQ-003 Local parameter W = N*L, bit width of the vector data ports.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset; asynchronous and active-high.
REQ-006 in_valid  input  1  operand beat present.
REQ-007 in_ready  output  1  block accepts a beat this cycle.
REQ-008 op  input  3  operation code, sampled with the beat.
REQ-009 sat  input  1  1 = saturating arithmetic, 0 = wrap-around; sampled with the beat.
REQ-010 a  input  W  vector operand; lane i = a[i*L +: L].
REQ-011 b  input  W  vector operand; scalar ops use b[L-1:0] only.
REQ-012 acc_clr  input  1  synchronous clear of all lane accumulators.
REQ-013 out_valid  output  1  result beat present.
REQ-014 out_ready  input  1  downstream accepts the result.
REQ-015 c  output  W  result vector.

Function
REQ-016 Ops: 0 NOP (c = a); 1 ADD (lane a+b); 2 SUB (lane a-b); 3 MUL (lane a*b); 4 SMUL (lane a*s); 5 THR (lane max(a,s)); 6 CMP (lane = 1 if a>s, else 0); 7 MAC (acc += a*b, c = new acc). Here s = b[L-1:0].
REQ-017 All lanes are unsigned L-bit values; lanes are fully independent, with no carry between lanes.
REQ-018 When sat=0, ADD/SUB/MUL/SMUL/MAC results are truncated to the low L bits (wrap-around).
REQ-019 When sat=1, any overflow clamps to 2^L-1 and any SUB underflow clamps to 0; for MAC, saturation applies to the accumulator update.
REQ-020 CMP and THR results are independent of sat.
REQ-021 The pipeline has two register stages: S1 captures op/sat/a/b; S2 captures the computed result. Latency from accepted beat to out_valid is 2 cycles.
REQ-022 advance = !out_valid || out_ready; in_ready = advance (combinational, no dependency on in_valid).
REQ-023 A beat is accepted when in_valid && in_ready.
REQ-024 When advance=1, S1 loads the input beat (valid = in_valid) and S2 loads S1's result (valid = S1 valid).
REQ-025 When advance=0, both stages hold; c and out_valid stay stable while out_valid && !out_ready.
REQ-026 A result transfers when out_valid && out_ready; full throughput is one beat per cycle when out_ready stays high.
REQ-027 Accumulators: N registers of L bits, updated only when a MAC beat moves from S1 into S2.
REQ-028 A back-to-back MAC in S1 uses the accumulator value already updated by the preceding MAC (no stale read).
REQ-029 acc_clr zeroes all accumulators at the next edge; if a MAC update occurs in the same cycle, the clear wins and that MAC's output uses acc = 0 + a*b (saturated/wrapped per sat).
REQ-030 Non-MAC ops never modify the accumulators.
REQ-031 Bubbles (S1 invalid) propagate as out_valid=0, with c unchanged from its previous value.

Reset
REQ-032 rst asserted forces immediately, independent of clk: S1/S2 valid = 0, out_valid = 0, c = 0, all accumulators = 0.
REQ-033 While rst is high, in_ready = 1; beats presented during reset are discarded.
REQ-034 Reset in mid-operation discards all in-flight beats; the first beat after deassertion appears 2 cycles after its acceptance.

Verification (N=4, L=16)
REQ-035 ADD, sat=0, a lanes {FFFF,1,2,3}, b lanes {2,1,1,1}, out_ready=1 -> 2 cycles later c lanes {0001,2,3,4}; same beat with sat=1 -> {FFFF,2,3,4}.
REQ-036 SUB, sat=1, a={5,0,9,1}, b={7,1,9,0} -> c={0,0,0,1}; CMP with s=5, a={6,5,4,FFFF} -> c={1,0,0,1}.
REQ-037 MAC streamed back-to-back, a=b={2,2,2,2} on 3 consecutive beats -> c = {4..}, {8..}, {C..}; assert acc_clr, then MAC a={3,..}, b={1,..} -> c={3,..}.
REQ-038 Backpressure: 4 beats streamed, out_ready low for 3 cycles once out_valid rises -> in_ready=0, c held stable, no beat lost or duplicated, output order preserved.
REQ-039 rst pulsed while 2 beats are in flight -> out_valid=0 and c=0 immediately; accumulators read 0 on the next MAC.
REQ-040 SMUL sat=1, s=0100, a={0100,0002,0,00FF} -> c={FFFF,0200,0,FF00}; same beat with sat=0 -> {0000,0200,0,FF00}.
